// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_if
//  Description : Operation/result bundle for alu_pipe. The master (producer /
//                consumer side) drives the request and result-accept signals.
//                The slave (alu_pipe) returns ready, the result and the flags.
//  Ports       : in_valid/in_ready/a/b/op  - request handshake and operands
//                out_valid/out_ready       - result handshake
//                y, z, n, c, v, err        - result value and flags
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic             err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, z, n, c, v, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, z, n, c, v, err
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Single-slot pipelined ALU with a valid/ready handshake on both
//                sides. Most opcodes produce their result one cycle after
//                acceptance. An optional unsigned shift-add multiplier
//                (opcode E) takes WIDTH+1 cycles.
//  Config      : `define ALU_PIPE_MUL_EN to build the multiplier. When it is
//                left undefined, opcode E is treated as an illegal opcode.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - alu_pipe_if slave (operands, opcode, result, flags)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    alu_pipe_if.slave  bus
);
    localparam int              SW      = $clog2(WIDTH);
    localparam logic [SW:0]     WIDTH_S = (SW+1)'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_ADC = 4'h2, OP_SBB = 4'h3,
                           OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_SHL = 4'h7,
                           OP_SHR = 4'h8, OP_ASR = 4'h9, OP_ROL = 4'hA, OP_ROR = 4'hB,
                           OP_CMP = 4'hC, OP_PAS = 4'hD, OP_MUL = 4'hE;

    // Result/flag registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;
    logic             cf_q, cf_d;

    // ------------------------------------------------------------------
    // Combinational ALU for the single-cycle opcodes
    // ------------------------------------------------------------------
    logic [SW-1:0]    w_amt;
    logic [SW:0]      w_ramt;
    logic             w_cin;
    logic [WIDTH:0]   w_sum, w_dif, w_shl, w_shr, w_asr;
    logic [WIDTH-1:0] w_rol, w_ror;
    logic             w_add_v, w_sub_v;
    logic [WIDTH-1:0] w_alu_y, w_flag_src;
    logic             w_alu_c, w_alu_v, w_alu_err;

    assign w_amt   = bus.b[SW-1:0];
    assign w_ramt  = WIDTH_S - {1'b0, w_amt};
    assign w_cin   = ((bus.op == OP_ADC) || (bus.op == OP_SBB)) ? cf_q : 1'b0;
    assign w_sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, w_cin};
    // Bit WIDTH of the difference is the borrow (a < b + cin).
    assign w_dif   = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, w_cin};
    assign w_add_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
    assign w_sub_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_dif[WIDTH-1] != bus.a[WIDTH-1]);
    // Extra bit catches the last bit shifted out; amount 0 leaves it 0.
    assign w_shl   = {1'b0, bus.a} << w_amt;
    assign w_shr   = {bus.a, 1'b0} >> w_amt;
    assign w_asr   = $signed({bus.a, 1'b0}) >>> w_amt;
    // Shift by WIDTH yields 0, so amount 0 degenerates to y = a.
    assign w_rol   = (bus.a << w_amt) | (bus.a >> w_ramt);
    assign w_ror   = (bus.a >> w_amt) | (bus.a << w_ramt);

    always_comb begin
        w_alu_y   = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_alu_err = 1'b0;
        case (bus.op)
            OP_ADD, OP_ADC: begin w_alu_y = w_sum[WIDTH-1:0]; w_alu_c = w_sum[WIDTH]; w_alu_v = w_add_v; end
            OP_SUB, OP_SBB: begin w_alu_y = w_dif[WIDTH-1:0]; w_alu_c = w_dif[WIDTH]; w_alu_v = w_sub_v; end
            OP_CMP:         begin w_alu_y = bus.a;            w_alu_c = w_dif[WIDTH]; w_alu_v = w_sub_v; end
            OP_AND:         w_alu_y = bus.a & bus.b;
            OP_OR:          w_alu_y = bus.a | bus.b;
            OP_XOR:         w_alu_y = bus.a ^ bus.b;
            OP_SHL:         begin w_alu_y = w_shl[WIDTH-1:0]; w_alu_c = w_shl[WIDTH]; end
            OP_SHR:         begin w_alu_y = w_shr[WIDTH:1];   w_alu_c = w_shr[0]; end
            OP_ASR:         begin w_alu_y = w_asr[WIDTH:1];   w_alu_c = w_asr[0]; end
            OP_ROL:         begin w_alu_y = w_rol; w_alu_c = (w_amt != '0) && w_rol[0]; end
            OP_ROR:         begin w_alu_y = w_ror; w_alu_c = (w_amt != '0) && w_ror[WIDTH-1]; end
            OP_PAS:         w_alu_y = bus.a;
            default:        w_alu_err = 1'b1;   // F, and E when no multiplier is built
        endcase
    end

    // CMP reports the flags of the subtraction while passing a through as y.
    assign w_flag_src = (bus.op == OP_CMP) ? w_dif[WIDTH-1:0] : w_alu_y;

    // ------------------------------------------------------------------
    // Handshake and control
    // ------------------------------------------------------------------
    logic w_accept, w_consume, w_load;

    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_consume = out_valid_q && bus.out_ready;

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [0:0] {IDLE = 1'b0, MULB = 1'b1} state_t;

    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH-1);

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d, w_prod_sum;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic               w_mul_done;

    assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign w_load       = w_accept && (bus.op != OP_MUL);
    assign w_prod_sum   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign w_mul_done   = (state_q == MULB) && (cnt_q == CNT_LAST);
`else
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign w_load       = w_accept;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        err_d       = err_q;
        cf_d        = cf_q;
`ifdef ALU_PIPE_MUL_EN
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
`endif
        if (w_consume) begin
            out_valid_d = 1'b0;
        end
        if (w_load) begin
            out_valid_d = 1'b1;
            y_d         = w_alu_y;
            z_d         = (w_flag_src == '0);
            n_d         = w_flag_src[WIDTH-1];
            c_d         = w_alu_c;
            v_d         = w_alu_v;
            err_d       = w_alu_err;
            cf_d        = w_alu_c;
        end
`ifdef ALU_PIPE_MUL_EN
        case (state_q)
            IDLE: begin
                if (w_accept && (bus.op == OP_MUL)) begin
                    // Operands are captured here; later a/b/op changes are ignored.
                    state_d  = MULB;
                    mcand_d  = {{WIDTH{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    prod_d   = '0;
                    cnt_d    = '0;
                end
            end
            MULB: begin
                prod_d   = w_prod_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (w_mul_done) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    y_d         = w_prod_sum[WIDTH-1:0];
                    z_d         = (w_prod_sum[WIDTH-1:0] == '0);
                    n_d         = w_prod_sum[WIDTH-1];
                    c_d         = |w_prod_sum[2*WIDTH-1:WIDTH];
                    v_d         = 1'b0;
                    err_d       = 1'b0;
                    cf_d        = |w_prod_sum[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
            cf_q        <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            err_q       <= err_d;
            cf_q        <= cf_d;
`ifdef ALU_PIPE_MUL_EN
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.z         = z_q;
    assign bus.n         = n_q;
    assign bus.c         = c_q;
    assign bus.v         = v_q;
    assign bus.err       = err_q;

endmodule
`default_nettype wire
